// File: rtl/csr_file_if.sv
// CSR access bus between the execute stage (master) and the CSR file (slave).
// Carries the address, read/write enables, write data, read data and the illegal flag.
interface csr_file_if;
    logic [11:0] csr_addr;
    logic        csr_rd_en;
    logic        csr_wr_en;
    logic [31:0] csr_wr_data;
    logic [31:0] csr_rd_data;
    logic        csr_illegal;

    modport master (
        output csr_addr,
        output csr_rd_en,
        output csr_wr_en,
        output csr_wr_data,
        input  csr_rd_data,
        input  csr_illegal
    );

    modport slave (
        input  csr_addr,
        input  csr_rd_en,
        input  csr_wr_en,
        input  csr_wr_data,
        output csr_rd_data,
        output csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR read/write, trap entry and mret updates, and the interrupt-pending decision.
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters and their user shadows.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0104,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Rst,
    csr_file_if.slave   bus,
    input  logic        instret,
    input  logic        trap,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMisa     = 12'h301;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMtval    = 12'h343;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMhartid  = 12'hF14;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMcycleh  = 12'hB80;
    localparam logic [11:0] AddrMinstret = 12'hB02;
    localparam logic [11:0] AddrMinstrh  = 12'hB82;
    localparam logic [11:0] AddrCycle    = 12'hC00;
    localparam logic [11:0] AddrCycleh   = 12'hC80;
    localparam logic [11:0] AddrInstret  = 12'hC02;
    localparam logic [11:0] AddrInstreth = 12'hC82;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic        addr_is_cnt;
    logic        addr_impl;
    logic        illegal;
    logic        wr_ok;
    logic [31:0] rdata;
    logic [31:0] cnt_rdata;

    assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
    assign mie_val     = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
    assign mip_val     = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};

    always_comb begin
        addr_is_cnt = 1'b0;
        case (bus.csr_addr)
            AddrMcycle, AddrMcycleh, AddrMinstret, AddrMinstrh,
            AddrCycle, AddrCycleh, AddrInstret, AddrInstreth: addr_is_cnt = 1'b1;
            default: addr_is_cnt = 1'b0;
        endcase
    end

    always_comb begin
        addr_impl = addr_is_cnt;
        case (bus.csr_addr)
            AddrMstatus, AddrMisa, AddrMie, AddrMtvec, AddrMscratch,
            AddrMepc, AddrMcause, AddrMtval, AddrMip, AddrMhartid: addr_impl = 1'b1;
            default: ;
        endcase
    end

    // Top two address bits 2'b11 mark read-only CSRs.
    assign illegal = bus.csr_rd_en &
                     (~addr_impl | (bus.csr_wr_en & (bus.csr_addr[11:10] == 2'b11)));
    assign wr_ok   = bus.csr_wr_en & ~illegal;

    always_comb begin
        rdata = cnt_rdata;
        case (bus.csr_addr)
            AddrMstatus:  rdata = mstatus_val;
            AddrMisa:     rdata = MISA_VAL;
            AddrMie:      rdata = mie_val;
            AddrMtvec:    rdata = mtvec_q;
            AddrMscratch: rdata = mscratch_q;
            AddrMepc:     rdata = mepc_q;
            AddrMcause:   rdata = mcause_q;
            AddrMtval:    rdata = mtval_q;
            AddrMip:      rdata = mip_val;
            AddrMhartid:  rdata = HART_ID;
            default:      ;
        endcase
    end

    assign bus.csr_rd_data = illegal ? 32'd0 : rdata;
    assign bus.csr_illegal = illegal;

    // Priority trap > mret > CSR write, resolved per register.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (wr_ok) begin
            case (bus.csr_addr)
                AddrMstatus: begin
                    mstatus_mie_d  = bus.csr_wr_data[3];
                    mstatus_mpie_d = bus.csr_wr_data[7];
                end
                AddrMie: begin
                    mie_mtie_d = bus.csr_wr_data[7];
                    mie_meie_d = bus.csr_wr_data[11];
                end
                AddrMtvec:    mtvec_d    = bus.csr_wr_data & ~32'h3;
                AddrMscratch: mscratch_d = bus.csr_wr_data;
                AddrMepc:     mepc_d     = bus.csr_wr_data & ~32'h1;
                AddrMcause:   mcause_d   = bus.csr_wr_data;
                AddrMtval:    mtval_d    = bus.csr_wr_data;
                default:      ;
            endcase
        end

        if (trap) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = trap_pc & ~32'h1;
            mcause_d       = trap_cause;
            mtval_d        = trap_val;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET & ~32'h3;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // A write to either half replaces that cycle's increment; the other half holds.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret};
        if (wr_ok) begin
            case (bus.csr_addr)
                AddrMcycle:   mcycle_d   = {mcycle_q[63:32], bus.csr_wr_data};
                AddrMcycleh:  mcycle_d   = {bus.csr_wr_data, mcycle_q[31:0]};
                AddrMinstret: minstret_d = {minstret_q[63:32], bus.csr_wr_data};
                AddrMinstrh:  minstret_d = {bus.csr_wr_data, minstret_q[31:0]};
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    always_comb begin
        cnt_rdata = 32'd0;
        case (bus.csr_addr)
            AddrMcycle, AddrCycle:     cnt_rdata = mcycle_q[31:0];
            AddrMcycleh, AddrCycleh:   cnt_rdata = mcycle_q[63:32];
            AddrMinstret, AddrInstret: cnt_rdata = minstret_q[31:0];
            AddrMinstrh, AddrInstreth: cnt_rdata = minstret_q[63:32];
            default:                   cnt_rdata = 32'd0;
        endcase
    end
`else
    logic unused_instret;

    assign unused_instret = instret;
    assign cnt_rdata      = 32'd0;
`endif

    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;
    assign irq_pending = mstatus_mie_q & ((mie_mtie_q & irq_timer) | (mie_meie_q & irq_ext));

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: directed cycles push expected values, a negedge monitor compares.
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;

    localparam int SelRd    = 0;
    localparam int SelIll   = 1;
    localparam int SelMepc  = 2;
    localparam int SelMtvec = 3;
    localparam int SelIrq   = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        instret = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_val = '0;
    logic        mret = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_timer = 1'b0;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        irq_pending;

    csr_file_if bus ();

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    csr_file dut (
        .clk        (clk),
        .Rst        (Rst),
        .bus        (bus),
        .instret    (instret),
        .trap       (trap),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc),
        .trap_val   (trap_val),
        .mret       (mret),
        .irq_ext    (irq_ext),
        .irq_timer  (irq_timer),
        .mtvec_o    (mtvec_o),
        .mepc_o     (mepc_o),
        .irq_pending(irq_pending)
    );

    task automatic push_exp(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // One bus cycle: inputs applied 1ns after the edge, committed at the next edge.
    task automatic cyc(input logic [11:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus.csr_addr    = a;
        bus.csr_rd_en   = rd;
        bus.csr_wr_en   = wr;
        bus.csr_wr_data = wd;
        trap            = 1'b0;
        mret            = 1'b0;
        instret         = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        cyc(a, 1'b1, 1'b0, 32'd0);
        push_exp(name, SelRd, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] wd);
        cyc(a, 1'b1, 1'b1, wd);
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] val);
        trap       = 1'b1;
        trap_pc    = pc;
        trap_cause = cause;
        trap_val   = val;
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SelRd:    act = bus.csr_rd_data;
                SelIll:   act = {31'd0, bus.csr_illegal};
                SelMepc:  act = mepc_o;
                SelMtvec: act = mtvec_o;
                default:  act = {31'd0, irq_pending};
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, want %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.csr_addr    = '0;
        bus.csr_rd_en   = 1'b0;
        bus.csr_wr_en   = 1'b0;
        bus.csr_wr_data = '0;
        repeat (2) @(posedge clk);
        #1 Rst = 1'b0;

        // Reset state
        rd(12'h300, 32'h0000_1800, "mstatus_reset");
        push_exp("mtvec_reset", SelMtvec, 32'h0);
        push_exp("mepc_reset", SelMepc, 32'h0);
        push_exp("irq_reset", SelIrq, 32'h0);
        push_exp("ill_reset", SelIll, 32'h0);

        // Field masking, no read-after-write bypass
        wr(12'h300, 32'hFFFF_FFFF);
        push_exp("mstatus_no_bypass", SelRd, 32'h0000_1800);
        rd(12'h300, 32'h0000_1888, "mstatus_mask");
        wr(12'h305, 32'h0000_1235);
        rd(12'h305, 32'h0000_1234, "mtvec_mask");
        push_exp("mtvec_o", SelMtvec, 32'h0000_1234);

        // mie / mip and interrupt pending
        wr(12'h304, 32'hFFFF_FFFF);
        rd(12'h304, 32'h0000_0880, "mie_mask");
        push_exp("irq_none", SelIrq, 32'h0);
        rd(12'h344, 32'h0000_0800, "mip_meip");
        irq_ext = 1'b1;
        push_exp("irq_ext_pending", SelIrq, 32'h1);
        wr(12'h344, 32'h0);
        push_exp("mip_write_legal", SelIll, 32'h0);
        rd(12'h344, 32'h0000_0080, "mip_write_ignored");
        irq_ext   = 1'b0;
        irq_timer = 1'b1;
        push_exp("irq_timer_pending", SelIrq, 32'h1);
        cyc(12'h0, 1'b0, 1'b0, 32'h0);
        irq_timer = 1'b0;

        // Trap entry then mret
        wr(12'h300, 32'h0000_0008);
        rd(12'h300, 32'h0000_1808, "mstatus_mie_only");
        do_trap(32'h0000_0103, 32'h8000_000B, 32'h0);
        rd(12'h300, 32'h0000_1880, "mstatus_after_trap");
        push_exp("mepc_o_trap", SelMepc, 32'h0000_0102);
        rd(12'h342, 32'h8000_000B, "mcause_trap");
        rd(12'h343, 32'h0, "mtval_trap");
        mret = 1'b1;
        rd(12'h300, 32'h0000_1888, "mstatus_after_mret");

        // Same-cycle priority
        wr(12'h341, 32'h0000_0001);
        do_trap(32'h0000_0200, 32'h0000_0002, 32'h0000_DEAD);
        rd(12'h341, 32'h0000_0200, "mepc_trap_wins");
        push_exp("mepc_o_trap_wins", SelMepc, 32'h0000_0200);
        rd(12'h343, 32'h0000_DEAD, "mtval_trap2");
        rd(12'h342, 32'h0000_0002, "mcause_trap2");
        wr(12'h340, 32'hCAFE_F00D);
        do_trap(32'h0000_0300, 32'h0000_0003, 32'h0);
        rd(12'h340, 32'hCAFE_F00D, "mscratch_with_trap");
        rd(12'h341, 32'h0000_0300, "mepc_trap3");
        rd(12'h300, 32'h0000_1800, "mstatus_trap_nested");
        wr(12'h300, 32'h0000_0088);
        mret = 1'b1;
        rd(12'h300, 32'h0000_1880, "mstatus_mret_wins");

        // Legality
        wr(12'hF14, 32'h1234_5678);
        push_exp("mhartid_write_ill", SelIll, 32'h1);
        push_exp("ill_rdata_zero", SelRd, 32'h0);
        rd(12'hF14, 32'h0, "mhartid_read");
        push_exp("mhartid_read_legal", SelIll, 32'h0);
        rd(12'h7C0, 32'h0, "unimpl_rdata");
        push_exp("unimpl_ill", SelIll, 32'h1);
        cyc(12'h7C0, 1'b0, 1'b0, 32'h0);
        push_exp("unimpl_no_rd_en", SelIll, 32'h0);
        rd(12'h301, 32'h4000_0104, "misa");
        wr(12'h301, 32'h0);
        rd(12'h301, 32'h4000_0104, "misa_write_ignored");

        // Asynchronous reset mid-cycle
        wr(12'h300, 32'h0000_0008);
        irq_ext = 1'b1;
        rd(12'h300, 32'h0000_1808, "mstatus_pre_rst");
        push_exp("irq_pre_rst", SelIrq, 32'h1);
        cyc(12'h300, 1'b1, 1'b0, 32'h0);
        #2 Rst = 1'b1;
        push_exp("mstatus_async_rst", SelRd, 32'h0000_1800);
        push_exp("mepc_async_rst", SelMepc, 32'h0);
        push_exp("mtvec_async_rst", SelMtvec, 32'h0);
        push_exp("irq_async_rst", SelIrq, 32'h0);
        @(posedge clk);
        #2 Rst = 1'b0;
        irq_ext = 1'b0;
        rd(12'h304, 32'h0, "mie_after_rst");
        rd(12'h340, 32'h0, "mscratch_after_rst");

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_written");
        rd(12'hB00, 32'h0, "mcycle_lo_wrap");
        rd(12'hB80, 32'h1, "mcycle_hi_carry");
        rd(12'hC80, 32'h1, "cycle_hi_shadow");
        repeat (3) begin
            cyc(12'h0, 1'b0, 1'b0, 32'h0);
            instret = 1'b1;
        end
        rd(12'hC02, 32'h3, "instret_shadow");
        rd(12'hB02, 32'h3, "minstret_lo");
        wr(12'hB82, 32'h5);
        rd(12'hB82, 32'h5, "minstret_hi_written");
        rd(12'hB02, 32'h3, "minstret_lo_holds");
        wr(12'hC00, 32'h0);
        push_exp("cycle_write_ill", SelIll, 32'h1);
`else
        rd(12'hB00, 32'h0, "mcycle_absent");
        push_exp("mcycle_absent_legal", SelIll, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, 32'h0, "mcycle_absent_write");
        repeat (3) begin
            cyc(12'h0, 1'b0, 1'b0, 32'h0);
            instret = 1'b1;
        end
        rd(12'hC02, 32'h0, "instret_absent");
`endif

        cyc(12'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
